// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Package : dma_pkg
// Brief   : Shared state encoding, config register map and CTRL bit positions
//           for the hold/holdACK block-copy engine.
// Rev     : 1.0  initial release
// ============================================================================
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_REL  = 3'd4,
    S_DONE = 3'd5
  } dma_state_t;

  localparam logic [4:0] c_a_src  = 5'b11000;
  localparam logic [4:0] c_a_dst  = 5'b11001;
  localparam logic [4:0] c_a_len  = 5'b11010;
  localparam logic [4:0] c_a_ctrl = 5'b11011;

  localparam int c_ctrl_start = 0;
  localparam int c_ctrl_clr   = 1;

endpackage
`default_nettype wire

// File: rtl/dma_hold_master_if.sv
`default_nettype none
// ============================================================================
// Interface : dma_hold_master_if
// Brief     : Config write port, CPU hold handshake and data-memory port.
// Rev       : 1.0  initial release
// ============================================================================
interface dma_hold_master_if #(
  parameter int wide = 32
);
  logic            cfg_we;
  logic [4:0]      cfg_addr;
  logic [wide-1:0] cfg_data;
  logic            hold;
  logic            hold_ack;
  logic            mem_we;
  logic [wide-1:0] mem_addr;
  logic [wide-1:0] mem_wd;
  logic [wide-1:0] mem_rd;
  logic            busy;
  logic            done;

  modport master (
    input  cfg_we, cfg_addr, cfg_data, hold_ack, mem_rd,
    output hold, mem_we, mem_addr, mem_wd, busy, done
  );

  modport slave (
    output cfg_we, cfg_addr, cfg_data, hold_ack, mem_rd,
    input  hold, mem_we, mem_addr, mem_wd, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/dma_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module : dma_cfg_regs
// Brief  : SRC/DST/LEN config registers, address stepping and sticky done flag.
// Rev    : 1.0  initial release
// ============================================================================
module dma_cfg_regs
  import dma_pkg::*;
#(
  parameter int         wide   = 32,
  parameter logic [4:0] A_SRC  = c_a_src,
  parameter logic [4:0] A_DST  = c_a_dst,
  parameter logic [4:0] A_LEN  = c_a_len,
  parameter logic [4:0] A_CTRL = c_a_ctrl
) (
  input  wire             clk,
  input  wire             rst,
  input  wire             i_cfg_we,
  input  wire [4:0]       i_cfg_addr,
  input  wire [wide-1:0]  i_cfg_data,
  input  wire             i_cfg_open,
  input  wire             i_step,
  input  wire             i_set_done,
  output logic [wide-1:0] o_src,
  output logic [wide-1:0] o_dst,
  output logic [wide-1:0] o_len,
  output logic            o_done,
  output logic            o_start
);

  logic [wide-1:0] r_src;
  logic [wide-1:0] r_dst;
  logic [wide-1:0] r_len;
  logic            r_done;
  logic            w_wr_src;
  logic            w_wr_dst;
  logic            w_wr_len;
  logic            w_clr;

  assign w_wr_src = i_cfg_we && i_cfg_open && (i_cfg_addr == A_SRC);
  assign w_wr_dst = i_cfg_we && i_cfg_open && (i_cfg_addr == A_DST);
  assign w_wr_len = i_cfg_we && i_cfg_open && (i_cfg_addr == A_LEN);
  assign o_start  = i_cfg_we && i_cfg_open && (i_cfg_addr == A_CTRL) && i_cfg_data[c_ctrl_start];
  // Clearing done is honoured in any state, unlike every other write
  assign w_clr    = i_cfg_we && (i_cfg_addr == A_CTRL) && i_cfg_data[c_ctrl_clr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_len  <= '0;
      r_done <= 1'b0;
    end else begin
      if (i_step) begin
        r_src <= r_src + wide'(4);
        r_dst <= r_dst + wide'(4);
      end else begin
        if (w_wr_src) r_src <= {i_cfg_data[wide-1:2], 2'b00};
        if (w_wr_dst) r_dst <= {i_cfg_data[wide-1:2], 2'b00};
      end
      if (w_wr_len) r_len <= {{(wide-16){1'b0}}, i_cfg_data[15:0]};
      // A set on the same edge wins: CTRL=3 with LEN=0 clears then completes
      if (i_set_done)  r_done <= 1'b1;
      else if (w_clr)  r_done <= 1'b0;
    end
  end

  assign o_src  = r_src;
  assign o_dst  = r_dst;
  assign o_len  = r_len;
  assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/dma_hold_master.sv
`default_nettype none
// ============================================================================
// Module : dma_hold_master
// Brief  : Memory-to-memory copy engine that requests the CPU bus via hold.
// Rev    : 1.0  initial release
// ============================================================================
module dma_hold_master
  import dma_pkg::*;
#(
  parameter int         wide   = 32,
  parameter logic [4:0] A_SRC  = c_a_src,
  parameter logic [4:0] A_DST  = c_a_dst,
  parameter logic [4:0] A_LEN  = c_a_len,
  parameter logic [4:0] A_CTRL = c_a_ctrl
) (
  input  wire               clk,
  input  wire               rst,
  dma_hold_master_if.master bus
);

  dma_state_t      r_state;
  dma_state_t      w_state_nxt;
  logic [wide-1:0] r_cnt;
  logic [wide-1:0] w_cnt_nxt;
  logic [wide-1:0] r_buf;
  logic [wide-1:0] w_buf_nxt;
  logic [wide-1:0] w_src;
  logic [wide-1:0] w_dst;
  logic [wide-1:0] w_len;
  logic            w_done;
  logic            w_start;
  logic            w_step;
  logic            w_set_done;
  logic            w_cfg_open;

  assign w_cfg_open = (r_state == S_IDLE) || (r_state == S_DONE);

  dma_cfg_regs #(
    .wide   (wide),
    .A_SRC  (A_SRC),
    .A_DST  (A_DST),
    .A_LEN  (A_LEN),
    .A_CTRL (A_CTRL)
  ) u_cfg (
    .clk        (clk),
    .rst        (rst),
    .i_cfg_we   (bus.cfg_we),
    .i_cfg_addr (bus.cfg_addr),
    .i_cfg_data (bus.cfg_data),
    .i_cfg_open (w_cfg_open),
    .i_step     (w_step),
    .i_set_done (w_set_done),
    .o_src      (w_src),
    .o_dst      (w_dst),
    .o_len      (w_len),
    .o_done     (w_done),
    .o_start    (w_start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // RD/WR only advance while granted; a withdrawn grant freezes the step
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_buf_nxt   = r_buf;
    w_step      = 1'b0;
    w_set_done  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          if (w_len == '0) begin
            w_state_nxt = S_DONE;
            w_set_done  = 1'b1;
          end else begin
            w_cnt_nxt   = w_len;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.hold_ack) w_state_nxt = S_RD;
      end
      S_RD: begin
        if (bus.hold_ack) begin
          w_buf_nxt   = bus.mem_rd;
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (bus.hold_ack) begin
          w_step      = 1'b1;
          w_cnt_nxt   = r_cnt - wide'(1);
          w_state_nxt = (r_cnt == wide'(1)) ? S_REL : S_RD;
        end
      end
      S_REL: begin
        if (!bus.hold_ack) begin
          w_state_nxt = S_DONE;
          w_set_done  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.hold     = (r_state == S_REQ) || (r_state == S_RD) || (r_state == S_WR);
  assign bus.mem_we   = (r_state == S_WR) && bus.hold_ack;
  assign bus.mem_addr = (r_state == S_RD) ? w_src :
                        (r_state == S_WR) ? w_dst : '0;
  assign bus.mem_wd   = (r_state == S_WR) ? r_buf : '0;
  assign bus.busy     = !w_cfg_open;
  assign bus.done     = w_done;

endmodule
`default_nettype wire

// File: tb/tb_dma_hold_master.sv
`default_nettype none
// ============================================================================
// Module : tb_dma_hold_master
// Brief  : Scoreboard bench for dma_hold_master with a CPU grant model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dma_hold_master;
  import dma_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_hold_master_if #(.wide(W)) bus();

  dma_hold_master #(.wide(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] dmem    [0:1023];
  logic [31:0] ref_mem [0:1023];
  assign bus.mem_rd = dmem[bus.mem_addr[11:2]];

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0, we_cnt = 0, hold_cnt = 0, own_cnt = 0;
  int   hold_fall_cyc = 0, done_rise_cyc = 0;
  int   gap = 0, cpu_wait = 0;
  logic drop_armed = 1'b0;
  logic [31:0] drop_addr = '0;
  logic prev_ack = 1'b0, prev_hold = 1'b0, prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus monitor: counts activity, pops the scoreboard on writes, updates memory
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (bus.hold) hold_cnt++;
      if (bus.hold && bus.hold_ack && prev_ack) own_cnt++;
      if (prev_hold && !bus.hold) hold_fall_cyc = cyc;
      if (!prev_done && bus.done) done_rise_cyc = cyc;
      if (gap > 0) begin
        check("gap_hold", {31'd0, bus.hold}, 32'd1);
        check("gap_we", {31'd0, bus.mem_we}, 32'd0);
      end
      if (bus.mem_we) begin
        wr_t e;
        we_cnt++;
        check("we_needs_ack", {31'd0, bus.hold_ack}, 32'd1);
        if (exp_q.size() == 0) begin
          check("spurious_write_q", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.mem_addr, e.addr);
          check("wr_data", bus.mem_wd, e.data);
        end
        dmem[bus.mem_addr[11:2]] = bus.mem_wd;
      end
    end
    prev_ack  = bus.hold_ack;
    prev_hold = bus.hold;
    prev_done = bus.done;
  end

  // CPU model: grants 3 cycles after hold, releases when hold drops, optional gap
  initial begin
    bus.hold_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (gap > 0) begin
        gap--;
        if (gap == 0) bus.hold_ack = 1'b1;
      end else if (drop_armed && bus.mem_we && bus.mem_addr == drop_addr) begin
        bus.hold_ack = 1'b0;
        gap          = 5;
        drop_armed   = 1'b0;
      end else if (bus.hold && !bus.hold_ack) begin
        cpu_wait++;
        if (cpu_wait == 3) begin
          bus.hold_ack = 1'b1;
          cpu_wait     = 0;
        end
      end else begin
        cpu_wait = 0;
        if (!bus.hold && bus.hold_ack) bus.hold_ack = 1'b0;
      end
    end
  end

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic preload(input int base, input int n, input logic [31:0] first, input logic [31:0] step);
    for (int i = 0; i < n; i++) begin
      dmem[base/4 + i]    = first + step * i;
      ref_mem[base/4 + i] = first + step * i;
    end
  endtask

  task automatic push_copy(input int src, input int dst, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({32'(dst + 4*i), ref_mem[src/4 + i]});
      ref_mem[dst/4 + i] = ref_mem[src/4 + i];
    end
  endtask

  task automatic check_mem(input string tag, input int dst, input int n);
    for (int i = 0; i < n; i++) check(tag, dmem[dst/4 + i], ref_mem[dst/4 + i]);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
  endtask

  task automatic setup(input int src, input int dst, input int len);
    cfg_write(c_a_src, src);
    cfg_write(c_a_dst, dst);
    cfg_write(c_a_len, len);
  endtask

  initial begin
    int n;
    int we0;
    rst          = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    for (int i = 0; i < 1024; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {31'd0, bus.hold}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wd", bus.mem_wd, 32'd0);
    rst = 1'b0;

    // Zero length: done next cycle, no bus request, no writes
    hold_cnt = 0; we_cnt = 0;
    cfg_write(c_a_len, 32'd0);
    cfg_write(c_a_ctrl, 32'd1);
    check("zero_done", {31'd0, bus.done}, 32'd1);
    check("zero_busy", {31'd0, bus.busy}, 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("zero_hold_cnt", 32'(hold_cnt), 32'd0);
    check("zero_we_cnt", 32'(we_cnt), 32'd0);

    cfg_write(c_a_ctrl, 32'd2);
    check("clr_done", {31'd0, bus.done}, 32'd0);

    // Basic copy
    preload(32'h40, 4, 32'h11, 32'h11);
    setup(32'h40, 32'h80, 4);
    push_copy(32'h40, 32'h80, 4);
    own_cnt = 0; we_cnt = 0;
    cfg_write(c_a_ctrl, 32'd1);
    wait_done("basic", 100);
    check("basic_own_cycles", 32'(own_cnt), 32'd8);
    check("basic_we_cnt", 32'(we_cnt), 32'd4);
    check("basic_hold_before_done", {31'd0, done_rise_cyc > hold_fall_cyc}, 32'd1);
    check("basic_hold_low", {31'd0, bus.hold}, 32'd0);
    check("basic_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 4; i++) check("basic_mem", dmem[32'h80/4 + i], 32'h11 * (i + 1));
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);
    check("basic_src_end", dut.u_cfg.r_src, 32'h50);
    check("basic_dst_end", dut.u_cfg.r_dst, 32'h90);

    // Config writes during a copy are ignored
    preload(32'h40, 4, 32'h5A0, 32'h3);
    setup(32'h40, 32'hC0, 4);
    push_copy(32'h40, 32'hC0, 4);
    we_cnt = 0;
    cfg_write(c_a_ctrl, 32'd3);
    check("busy_done_cleared", {31'd0, bus.done}, 32'd0);
    check("busy_started", {31'd0, bus.busy}, 32'd1);
    cfg_write(c_a_src, 32'h200);
    cfg_write(c_a_ctrl, 32'd1);
    wait_done("busy", 100);
    check("busy_src_end", dut.u_cfg.r_src, 32'h50);
    check("busy_dst_end", dut.u_cfg.r_dst, 32'hD0);
    check("busy_we_cnt", 32'(we_cnt), 32'd4);
    check_mem("busy_mem", 32'hC0, 4);
    check("busy_q_empty", 32'(exp_q.size()), 32'd0);

    // Grant withdrawn during the write of word 2
    preload(32'h100, 4, 32'hCAFE_0001, 32'h101);
    setup(32'h100, 32'h180, 4);
    push_copy(32'h100, 32'h180, 4);
    drop_addr  = 32'h184;
    drop_armed = 1'b1;
    cfg_write(c_a_ctrl, 32'd3);
    wait_done("gap", 200);
    check("gap_happened", {31'd0, drop_armed}, 32'd0);
    check_mem("gap_mem", 32'h180, 4);
    check("gap_q_empty", 32'(exp_q.size()), 32'd0);

    // Clear, then combined clear+start with an unaligned one-word copy
    cfg_write(c_a_ctrl, 32'd2);
    check("restart_clr", {31'd0, bus.done}, 32'd0);
    preload(32'h60, 1, 32'h600D_F00D, 32'd0);
    setup(32'h63, 32'h1C2, 1);
    push_copy(32'h60, 32'h1C0, 1);
    cfg_write(c_a_ctrl, 32'd3);
    check("restart_done_low", {31'd0, bus.done}, 32'd0);
    check("restart_busy", {31'd0, bus.busy}, 32'd1);
    wait_done("restart", 100);
    check("restart_src_end", dut.u_cfg.r_src, 32'h64);
    check("restart_dst_end", dut.u_cfg.r_dst, 32'h1C4);
    check_mem("restart_mem", 32'h1C0, 1);

    // Reset after the first word is written
    preload(32'h20, 4, 32'hA1, 32'h1);
    setup(32'h20, 32'h80, 4);
    push_copy(32'h20, 32'h80, 1);
    we0 = we_cnt;
    cfg_write(c_a_ctrl, 32'd1);
    n = 0;
    while (we_cnt == we0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_mid_first_write", 32'(we_cnt - we0), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_hold", {31'd0, bus.hold}, 32'd0);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_done", {31'd0, bus.done}, 32'd0);
    check("rst_mid_src", dut.u_cfg.r_src, 32'd0);
    check("rst_mid_dst", dut.u_cfg.r_dst, 32'd0);
    check("rst_mid_len", dut.u_cfg.r_len, 32'd0);
    check("rst_mid_cnt", dut.r_cnt, 32'd0);
    check("rst_mid_buf", dut.r_buf, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rst_mid_word0", dmem[32'h80/4], 32'hA1);
    check("rst_mid_word1", dmem[32'h84/4], 32'h22);
    check("rst_mid_hold_after", {31'd0, bus.hold}, 32'd0);
    check("rst_mid_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
